aes_dec_ctrl: RTL and testbench

AES_DEC_CTRL -- requirements
Module: aes_dec_ctrl

---
 rtl/aes_pkg.sv | 13 +
 rtl/aes_dec_fifo.sv | 58 +++++
 rtl/aes_dec_ctrl.sv | 129 ++++++++++++
 tb/tb_aes_dec_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES decrypt-controller types: block width and controller FSM state.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [1:0] {
    StNoKey,
    StSettle,
    StRun,
    StDrain
  } aes_state_e;

endpackage

// File: rtl/aes_dec_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop together at full keep the count.
module aes_dec_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 128
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [Width-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [Width-1:0]               rdata_o,
  output logic                           valid_o,
  output logic [$clog2(Depth + 1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             empty, full, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty;
  // A pop frees the slot the simultaneous push lands in.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = ~empty;
  assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/aes_dec_ctrl.sv
// Key/ciphertext sequencing around a fixed-latency AES decrypt pipeline with credit-based output buffer.
// Optional block counter output blk_cnt is enabled by defining AES_DEC_CTRL_STATS_EN.
module aes_dec_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned LAT        = 10,
  parameter int unsigned KEY_SETTLE = 10,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [AES_BLK_W-1:0] key_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [AES_BLK_W-1:0] s_data,
  output logic [AES_BLK_W-1:0] dp_key,
  output logic [AES_BLK_W-1:0] dp_ct,
  input  logic [AES_BLK_W-1:0] dp_pt,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [AES_BLK_W-1:0] m_data,
`ifdef AES_DEC_CTRL_STATS_EN
  output logic [31:0]          blk_cnt,
`endif
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam int unsigned SetW = $clog2(KEY_SETTLE + 1);

  aes_state_e           state_q, state_d;
  logic [SetW-1:0]      settle_q, settle_d;
  logic [LAT-1:0]       sr_q;
  logic [CntW-1:0]      inflight_q, inflight_d, fifo_count;
  logic [SumW-1:0]      credit_used;
  logic [AES_BLK_W-1:0] dp_key_q, dp_ct_q;
  logic                 key_acc, issue, tail, pop;

  assign tail        = sr_q[LAT-1];
  assign key_ready   = (state_q == StNoKey) | ((state_q == StDrain) & (inflight_q == '0));
  assign key_acc     = key_valid & key_ready;
  // Every accepted block owns a FIFO slot until popped, so the buffer can never overflow.
  assign credit_used = SumW'(inflight_q) + SumW'(fifo_count);
  assign s_ready     = (state_q == StRun) & ~key_valid & (credit_used < SumW'(FIFO_DEPTH));
  assign issue       = s_valid & s_ready;
  assign pop         = m_valid & m_ready;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      StNoKey, StDrain: begin
        if (key_acc) begin
          state_d  = StSettle;
          settle_d = SetW'(KEY_SETTLE - 1);
        end
      end
      StSettle: begin
        if (settle_q <= SetW'(1)) state_d = StRun;
        else                      settle_d = settle_q - SetW'(1);
      end
      StRun: begin
        if (key_valid) state_d = StDrain;
      end
      default: state_d = StNoKey;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, tail})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StNoKey;
      settle_q   <= '0;
      sr_q       <= '0;
      inflight_q <= '0;
      dp_key_q   <= '0;
      dp_ct_q    <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      sr_q       <= (sr_q << 1) | LAT'(issue);
      inflight_q <= inflight_d;
      if (key_acc) dp_key_q <= key_data;
      if (issue)   dp_ct_q  <= s_data;
    end
  end

  assign dp_key = dp_key_q;
  assign dp_ct  = dp_ct_q;

  aes_dec_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (AES_BLK_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (tail),
    .wdata_i (dp_pt),
    .pop_i   (pop),
    .rdata_o (m_data),
    .valid_o (m_valid),
    .count_o (fifo_count)
  );

  assign busy = (inflight_q != '0) | m_valid;

`ifdef AES_DEC_CTRL_STATS_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)      blk_cnt_q <= '0;
    else if (pop) blk_cnt_q <= blk_cnt_q + 32'd1;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Directed + randomized bench for aes_dec_ctrl with a stub decrypt pipeline and a queue scoreboard.
module tb_aes_dec_ctrl;

  localparam int unsigned LAT        = 10;
  localparam int unsigned KEY_SETTLE = 10;
  localparam int unsigned FIFO_DEPTH = 16;

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY1 = 128'hfedcba98765432100123456789abcdef;

  logic         clk, rst;
  logic         key_valid, key_ready, s_valid, s_ready, m_valid, m_ready, busy;
  logic [127:0] key_data, s_data, dp_key, dp_ct, dp_pt, m_data;
`ifdef AES_DEC_CTRL_STATS_EN
  logic [31:0]  blk_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;

  aes_dec_ctrl #(
    .LAT        (LAT),
    .KEY_SETTLE (KEY_SETTLE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_data  (key_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .dp_key    (dp_key),
    .dp_ct     (dp_ct),
    .dp_pt     (dp_pt),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
`ifdef AES_DEC_CTRL_STATS_EN
    .blk_cnt   (blk_cnt),
`endif
    .busy      (busy)
  );

  // Standalone FIFO instance to exercise push+pop while full.
  logic         f_rst, f_push, f_pop, f_valid;
  logic [127:0] f_wdata, f_rdata;
  logic [4:0]   f_count;

  aes_dec_fifo #(
    .Depth (16),
    .Width (128)
  ) u_fifo_tb (
    .clk_i   (clk),
    .rst_i   (f_rst),
    .push_i  (f_push),
    .wdata_i (f_wdata),
    .pop_i   (f_pop),
    .rdata_o (f_rdata),
    .valid_o (f_valid),
    .count_o (f_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub decrypt: the one known vector, otherwise a key-dependent scramble.
  function automatic logic [127:0] dec_f(input logic [127:0] ct, input logic [127:0] key);
    if (ct == CT0 && key == KEY0) return PT0;
    return ct ^ {key[63:0], key[127:64]} ^ 128'h5a5a;
  endfunction

  // Pipeline model: ciphertext seen in cycle c is returned in cycle c+LAT-1, captured at edge c+LAT.
  logic [127:0] pipe_ct [LAT-1];
  logic [127:0] pipe_key [LAT-1];
  always @(posedge clk) begin
    for (int i = LAT - 2; i > 0; i--) begin
      pipe_ct[i]  <= pipe_ct[i-1];
      pipe_key[i] <= pipe_key[i-1];
    end
    pipe_ct[0]  <= dp_ct;
    pipe_key[0] <= dp_key;
  end
  assign dp_pt = dec_f(pipe_ct[LAT-2], pipe_key[LAT-2]);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h required %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected plaintext per accepted block, in order, under the key held at issue.
  logic [127:0] exp_q[$];
  logic [127:0] key_m;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", m_data, 128'hx);
        end else begin
          chk("out_data", m_data, exp_q.pop_front());
          rx_cnt++;
        end
      end
      if (s_valid && s_ready) exp_q.push_back(dec_f(s_data, key_m));
      if (key_valid && key_ready) key_m = key_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input int max_cyc, input bit rnd, output int sent);
    sent = 0;
    for (int c = 0; c < max_cyc; c++) begin
      s_valid = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
      s_data  = {$urandom, $urandom, $urandom, $urandom};
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      #1;
      if (s_valid && s_ready) sent++;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int w = 0;
    while (busy && w < max_cyc) begin
      tick();
      w++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic load_key(input logic [127:0] k);
    key_valid = 1'b1;
    key_data  = k;
    #1;
    chk("key_ready_on_load", key_ready, 1'b1);
    tick();
    key_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int w, sent, rx0;
    logic [127:0] fq[$];
    logic [127:0] v;

    rst = 1'b1; key_valid = 1'b0; key_data = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    f_rst = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_wdata = '0;
    key_m = '0;
    tick(); tick();

    // Reset state
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_dp_key", dp_key, '0);
    chk("rst_dp_ct", dp_ct, '0);
    rst = 1'b0;
    f_rst = 1'b0;

    // Known-answer block: settle time and issue-to-output latency
    load_key(KEY0);
    chk("dp_key_loaded", dp_key, KEY0);
    s_valid = 1'b1;
    s_data  = CT0;
    #1;
    w = 0;
    while (!s_ready && w < 50) begin
      tick();
      w++;
    end
    chk("settle_cycles", 128'(w), 128'(KEY_SETTLE - 1));
    tick();
    chk("dp_ct_issued", dp_ct, CT0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    w = 0;
    while (!m_valid && w < 50) begin
      tick();
      w++;
    end
    chk("issue_to_m_valid", 128'(w), 128'(LAT));
    chk("kat_plaintext", m_data, PT0);
    chk("busy_with_output", busy, 1'b1);
    tick();
    chk("kat_popped", m_valid, 1'b0);
    chk("kat_idle", busy, 1'b0);

    // Backpressure: 20 offered, only FIFO_DEPTH accepted, then all drain in order
    m_ready = 1'b0;
    rx0 = rx_cnt;
    stream(20, 60, 1'b0, sent);
    chk("bp_accepted", 128'(sent), 128'(FIFO_DEPTH));
    chk("bp_s_ready_low", s_ready, 1'b0);
    chk("bp_m_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    stream(4, 40, 1'b0, sent);
    chk("bp_rest_accepted", 128'(sent), 128'd4);
    wait_idle("bp_drain_idle", 100);
    chk("bp_all_out", 128'(rx_cnt - rx0), 128'd20);

    // Key change with 5 blocks in flight
    stream(5, 5, 1'b0, sent);
    chk("kc_issued", 128'(sent), 128'd5);
    key_valid = 1'b1;
    key_data  = KEY1;
    s_valid   = 1'b1;
    #1;
    chk("kc_s_ready_drop", s_ready, 1'b0);
    chk("kc_key_ready_low", key_ready, 1'b0);
    w = 0;
    while (!key_ready && w < 50) begin
      tick();
      w++;
    end
    chk("kc_key_ready_delay", 128'(w), 128'(LAT));
    tick();
    key_valid = 1'b0;
    chk("kc_dp_key", dp_key, KEY1);
    w = 0;
    while (!s_ready && w < 50) begin
      tick();
      w++;
    end
    chk("kc_settle_cycles", 128'(w), 128'(KEY_SETTLE - 1));
    tick();
    s_valid = 1'b0;
    wait_idle("kc_idle", 100);
    chk("kc_scoreboard_empty", 128'(exp_q.size()), 128'd0);

    // Randomized traffic with random backpressure
    rx0 = rx_cnt;
    stream(150, 500, 1'b1, sent);
    m_ready = 1'b1;
    wait_idle("rnd_idle", 200);
    chk("rnd_count", 128'(rx_cnt - rx0), 128'(sent));

    // FIFO push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      f_push = 1'b1;
      f_wdata = v;
      fq.push_back(v);
      tick();
    end
    f_push = 1'b0;
    chk("fifo_full_count", 128'(f_count), 128'd16);
    for (int j = 0; j < 5; j++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      f_push = 1'b1;
      f_pop = 1'b1;
      f_wdata = v;
      #1;
      chk("fifo_full_head", f_rdata, fq.pop_front());
      fq.push_back(v);
      tick();
      chk("fifo_full_pushpop_count", 128'(f_count), 128'd16);
    end
    f_push = 1'b0;
    for (int j = 0; j < 16; j++) begin
      f_pop = 1'b1;
      #1;
      chk("fifo_drain_head", f_rdata, fq.pop_front());
      tick();
    end
    f_pop = 1'b0;
    chk("fifo_empty_after", f_valid, 1'b0);

    // Reset with 8 blocks buffered
    m_ready = 1'b0;
    stream(8, 8, 1'b0, sent);
    chk("rs_issued", 128'(sent), 128'd8);
    for (int i = 0; i < LAT + 2; i++) tick();
    chk("rs_buffered", m_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rs_m_valid", m_valid, 1'b0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_key_ready", key_ready, 1'b1);
    chk("rs_s_ready", s_ready, 1'b0);
    tick();
    chk("rs_still_empty", m_valid, 1'b0);

    // 100 transfers after a fresh key
    load_key(KEY0);
    m_ready = 1'b1;
    rx0 = rx_cnt;
    stream(100, 300, 1'b0, sent);
    wait_idle("stats_idle", 100);
    chk("stats_sent", 128'(sent), 128'd100);
    chk("stats_rx", 128'(rx_cnt - rx0), 128'd100);
`ifdef AES_DEC_CTRL_STATS_EN
    chk("blk_cnt_100", 128'(blk_cnt), 128'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("blk_cnt_rst", 128'(blk_cnt), 128'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
